cpu_clk_ctrl: RTL
=================

// Module: cpu_clk_ctrl
// PURPOSE
//  Consumer end of clk_div2: samples its divided clock (div_clk_in) in the clk domain and emits
//  one-cycle enables on its rising (clk_en) and falling (clk_en_n) edges to drive the 8-bit CPU.
//  Adds free-run / single-step / halt control, with a debounced step button.
//  Sits between clk_div2 and the CPU core; the CPU uses the enables and never a derived clock.
// PARAMETERS
//  DEBOUNCE_CYCLES  4   consecutive stable clk samples required to accept a step_btn level change
// PORTS
//  clk         in   1  system clock (same clock that drives clk_div2)
//  rst         in   1  synchronous, active-high reset
//  div_clk_in  in   1  divided clock from clk_div2.clk_out (synchronous to clk)
//  run_mode    in   1  1 = free-run, 0 = manual single-step
//  step_btn    in   1  raw step push-button (bouncy, active-high)
//  hlt         in   1  CPU HLT request (level)
//  clk_en      out  1  1-cycle pulse: CPU rising-edge work
//  clk_en_n    out  1  1-cycle pulse: CPU falling-edge work (control-word latch)
//  halted      out  1  sticky halt indicator
// BEHAVIOUR
//  - Reset: clk_en=0, clk_en_n=0, halted=0, state=IDLE, pending=0, div_q=0, debounced btn=0.
//  - Edge detect: div_q <= div_clk_in; rise = div_clk_in & ~div_q; fall = ~div_clk_in & div_q.
//  - Outputs registered: edge seen at cycle t -> pulse at t+1, width exactly one clk.
//  - pending: set with clk_en, cleared with clk_en_n; clk_en_n fires only when pending=1, so
//    rise/fall pulses always pair; never two clk_en without an intervening clk_en_n.
//  - States: IDLE, RUN, STEP_ARM, STEP_DONE, HALTED.
//    IDLE: run_mode=1 -> RUN; debounced press (0->1) and run_mode=0 -> STEP_ARM.
//    RUN: clk_en on every rise; leave only when pending=0 (after the fall pulse):
//      hlt=1 -> HALTED (hlt priority); else run_mode=0 -> IDLE.
//    STEP_ARM: next rise -> one clk_en; next fall -> one clk_en_n -> STEP_DONE.
//    STEP_DONE: wait for debounced release -> IDLE (one press = exactly one cycle).
//    HALTED: no enables, halted=1, ignores run_mode/step_btn; exit only by rst.
//  - hlt in IDLE, or in STEP_ARM/STEP_DONE with pending=0 -> HALTED.
//  - Press while not in IDLE: ignored, not queued.
//  - Simultaneous rise and hlt with pending=0 in RUN: hlt wins, no clk_en.
//  - run_mode changes in STEP_ARM/STEP_DONE: step completes first, then IDLE re-evaluates.
//  - rst mid-operation (incl. pending=1): all state cleared next clk; no pulse follows it.
//  - Debounce: counter 0..DEBOUNCE_CYCLES-1 ($clog2 width); reload on mismatch with
//    accepted level; accept new level when raw level held DEBOUNCE_CYCLES cycles.
// STRUCTURE
//  - Include file cpu_clk_pkg.vh: state encodings (IDLE=0, RUN=1, STEP_ARM=2, STEP_DONE=3,
//    HALTED=4, 3-bit) shared with CPU debug/monitor logic.
//  - Sub-module btn_debounce #(DEBOUNCE_CYCLES) (clk, rst, btn_raw, btn_db); press/release
//    edges derived in cpu_clk_ctrl.
//  - Top: edge detect, pending flag, FSM, registered outputs.
// TESTING  (clk 10 ns; clk_div2 instance drives div_clk_in; rst=1 for first 12 ns)
//  1 Reset: rst=1, div clock toggling -> clk_en=clk_en_n=halted=0 throughout; state=IDLE.
//  2 Free-run: run_mode=1, 200 ns -> clk_en every 2 clk, clk_en_n alternating in between,
//    pulse count matches div rise count +-1, never two clk_en back-to-back without clk_en_n.
//  3 Step: run_mode=0, step_btn high 100 ns -> exactly 1 clk_en + 1 clk_en_n; 2-cycle bounce
//    glitches (20 ns) -> 0 pulses; second clean press -> second pair.
//  4 Halt: run_mode=1, hlt=1 just after a clk_en -> clk_en_n still emitted, then halted=1,
//    no pulses for 300 ns despite step presses and run_mode toggles; rst -> halted=0.
//  5 Mode switch: run_mode 1->0 cycle after clk_en -> matching clk_en_n, then no pulses.
//  6 Reset mid-step: rst=1 between step clk_en and clk_en_n -> no clk_en_n; halted=0; IDLE.

Source files
------------

// File: rtl/cpu_clk_ctrl_pkg.sv
// Clock-controller state encodings, shared with CPU debug/monitor logic.
package cpu_clk_ctrl_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_RUN       = 3'd1;
   localparam logic [2:0] ST_STEP_ARM  = 3'd2;
   localparam logic [2:0] ST_STEP_DONE = 3'd3;
   localparam logic [2:0] ST_HALTED    = 3'd4;

   function automatic logic rise_of(input logic cur, input logic prev);
      return cur & ~prev;
   endfunction

endpackage

// File: rtl/cpu_clk_ctrl_debounce.sv
// Step-button debouncer: accepts a new level once the raw input has disagreed with the
// accepted level for DEBOUNCE_CYCLES consecutive samples; output is registered.
module cpu_clk_ctrl_debounce #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic btn_raw,
   output logic btn_db
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] cnt_d, cnt_q;
   logic             db_d, db_q;

   always_comb begin
      cnt_d = cnt_q;
      db_d  = db_q;
      if (btn_raw == db_q) begin
         cnt_d = RELOAD;
      end else if (cnt_q == '0) begin
         db_d  = btn_raw;
         cnt_d = RELOAD;
      end else begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= RELOAD;
         db_q  <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         db_q  <= db_d;
      end
   end

   assign btn_db = db_q;

endmodule

// File: rtl/cpu_clk_ctrl.sv
// Turns the clk_div2 output into paired one-cycle CPU enables with run/step/halt control.
// Edge seen in cycle t produces its pulse in cycle t+1; clk_en_n always follows its clk_en.
module cpu_clk_ctrl
   import cpu_clk_ctrl_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic div_clk_in,
   input  logic run_mode,
   input  logic step_btn,
   input  logic hlt,
   output logic clk_en,
   output logic clk_en_n,
   output logic halted
);

   logic       div_q, btn_prev_q;
   logic [2:0] state_d, state_q;
   logic       pending_d, pending_q;
   logic       clk_en_d, clk_en_q;
   logic       clk_en_n_d, clk_en_n_q;
   logic       halted_d, halted_q;
   logic       btn_db, rise, fall, press;

   cpu_clk_ctrl_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_debounce (
      .clk     (clk),
      .rst     (rst),
      .btn_raw (step_btn),
      .btn_db  (btn_db)
   );

   assign rise  = rise_of(div_clk_in, div_q);
   assign fall  = rise_of(div_q, div_clk_in);
   assign press = rise_of(btn_db, btn_prev_q);

   always_comb begin
      state_d    = state_q;
      clk_en_d   = 1'b0;
      clk_en_n_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (hlt)           state_d = ST_HALTED;
            else if (run_mode) state_d = ST_RUN;
            else if (press)    state_d = ST_STEP_ARM;
         end
         ST_RUN: begin
            // An open rise/fall pair must close before any mode change is honoured.
            if (pending_q)      clk_en_n_d = fall;
            else if (hlt)       state_d = ST_HALTED;
            else if (!run_mode) state_d = ST_IDLE;
            else                clk_en_d = rise;
         end
         ST_STEP_ARM: begin
            if (pending_q) begin
               if (fall) begin
                  clk_en_n_d = 1'b1;
                  state_d    = ST_STEP_DONE;
               end
            end else if (hlt) begin
               state_d = ST_HALTED;
            end else begin
               clk_en_d = rise;
            end
         end
         ST_STEP_DONE: begin
            if (hlt)          state_d = ST_HALTED;
            else if (!btn_db) state_d = ST_IDLE;
         end
         ST_HALTED: state_d = ST_HALTED;
         default:   state_d = ST_IDLE;
      endcase

      pending_d = pending_q;
      if (clk_en_d)        pending_d = 1'b1;
      else if (clk_en_n_d) pending_d = 1'b0;
      halted_d = (state_d == ST_HALTED);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         div_q      <= 1'b0;
         btn_prev_q <= 1'b0;
         state_q    <= ST_IDLE;
         pending_q  <= 1'b0;
         clk_en_q   <= 1'b0;
         clk_en_n_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         div_q      <= div_clk_in;
         btn_prev_q <= btn_db;
         state_q    <= state_d;
         pending_q  <= pending_d;
         clk_en_q   <= clk_en_d;
         clk_en_n_q <= clk_en_n_d;
         halted_q   <= halted_d;
      end
   end

   assign clk_en   = clk_en_q;
   assign clk_en_n = clk_en_n_q;
   assign halted   = halted_q;

endmodule
